// File: rtl/tile_sequencer.sv
// tile_sequencer: walks the M/K/N tiles of one matmul job and launches the
// weight fill, weight drain, MMU and writeback engines for every tile.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | no job; waits for start, latches dims and relu_in
// CHECK  | validates dims, computes tile counts, clears m/k/n
// WFILL  | weight fill of W tile (k, n) in flight
// WDRAIN | weight drain into the array in flight
// MMU    | stream of A tile (m, k) in flight; accumulate unless k == 0
// WB     | writeback of output tile (m, n) in flight
// DONE   | one-cycle done pulse
// ERR    | one-cycle done + error pulse for illegal dims
module tile_sequencer #(
    parameter int WIDTH_HEIGHT = 16,
    parameter int MAX_MAT_WH   = 128,
    parameter int DIM_WIDTH    = $clog2(MAX_MAT_WH) + 1,
    parameter int TILE_WIDTH   = $clog2(MAX_MAT_WH / WIDTH_HEIGHT),
    parameter int ADDR_WIDTH   = $clog2(MAX_MAT_WH * MAX_MAT_WH / WIDTH_HEIGHT)
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            start,
    input  logic                            abort,
    input  logic                            relu_in,
    input  logic [DIM_WIDTH-1:0]            dim_m,
    input  logic [DIM_WIDTH-1:0]            dim_k,
    input  logic [DIM_WIDTH-1:0]            dim_n,
    input  logic                            weight_fill_done,
    input  logic                            weight_drain_done,
    input  logic                            mmu_done,
    input  logic                            wb_done,
    output logic                            weight_fill_start,
    output logic                            weight_drain_start,
    output logic                            mmu_start,
    output logic                            wb_start,
    output logic [ADDR_WIDTH-1:0]           weight_base,
    output logic [ADDR_WIDTH-1:0]           input_base,
    output logic [ADDR_WIDTH-1:0]           output_base,
    output logic [TILE_WIDTH-1:0]           submat_row,
    output logic [TILE_WIDTH-1:0]           submat_col,
    output logic                            accum_first,
    output logic [$clog2(WIDTH_HEIGHT):0]   tile_rows,
    output logic [$clog2(WIDTH_HEIGHT):0]   tile_cols,
    output logic                            relu_en,
    output logic                            busy,
    output logic                            done,
    output logic                            error
);

    localparam int LOG_WH    = $clog2(WIDTH_HEIGHT);
    localparam int CNT_WIDTH = TILE_WIDTH + 1;
    localparam int EXT_WIDTH = LOG_WH + 1;

    typedef enum logic [2:0] {
        S_IDLE, S_CHECK, S_WFILL, S_WDRAIN, S_MMU, S_WB, S_DONE, S_ERR
    } state_t;

    state_t                state_q, state_d;
    logic                  first_q, first_d;
    logic [TILE_WIDTH-1:0] m_q, m_d, k_q, k_d, n_q, n_d;
    logic [CNT_WIDTH-1:0]  tm_q, tk_q, tn_q;
    logic [DIM_WIDTH-1:0]  dim_m_q, dim_k_q, dim_n_q;
    logic                  relu_q;
    logic                  dims_bad;
    logic [DIM_WIDTH-1:0]  tm_sum, tk_sum, tn_sum;
    logic                  m_last, k_last, n_last;
    state_t                adv_state;
    logic [TILE_WIDTH-1:0] adv_m, adv_k, adv_n;

    assign dims_bad = (dim_m_q == '0) || (dim_m_q > DIM_WIDTH'(MAX_MAT_WH)) ||
                      (dim_k_q == '0) || (dim_k_q > DIM_WIDTH'(MAX_MAT_WH)) ||
                      (dim_n_q == '0) || (dim_n_q > DIM_WIDTH'(MAX_MAT_WH));

    // ceil(dim / WIDTH_HEIGHT); the sum cannot overflow for legal dims
    assign tm_sum = dim_m_q + DIM_WIDTH'(WIDTH_HEIGHT - 1);
    assign tk_sum = dim_k_q + DIM_WIDTH'(WIDTH_HEIGHT - 1);
    assign tn_sum = dim_n_q + DIM_WIDTH'(WIDTH_HEIGHT - 1);

    assign m_last = (CNT_WIDTH'(m_q) + CNT_WIDTH'(1)) >= tm_q;
    assign k_last = (CNT_WIDTH'(k_q) + CNT_WIDTH'(1)) >= tk_q;
    assign n_last = (CNT_WIDTH'(n_q) + CNT_WIDTH'(1)) >= tn_q;

    // Position after an m pass finishes: m inner, then k, then n outer
    always_comb begin
        adv_state = S_MMU;
        adv_m     = m_q + TILE_WIDTH'(1);
        adv_k     = k_q;
        adv_n     = n_q;
        if (m_last) begin
            adv_m = '0;
            if (!k_last) begin
                adv_k     = k_q + TILE_WIDTH'(1);
                adv_state = S_WFILL;
            end else if (!n_last) begin
                adv_n     = n_q + TILE_WIDTH'(1);
                adv_k     = '0;
                adv_state = S_WFILL;
            end else begin
                adv_state = S_DONE;
            end
        end
    end

    // Next-state logic; first_d marks the entry cycle of the next state,
    // which both fires the engine start and masks same-cycle done pulses
    always_comb begin
        state_d = state_q;
        first_d = 1'b0;
        m_d     = m_q;
        k_d     = k_q;
        n_d     = n_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_CHECK;
                    first_d = 1'b1;
                end
            end
            S_CHECK: begin
                m_d = '0;
                k_d = '0;
                n_d = '0;
                first_d = 1'b1;
                state_d = dims_bad ? S_ERR : S_WFILL;
            end
            S_WFILL: begin
                if (!first_q && weight_fill_done) begin
                    state_d = S_WDRAIN;
                    first_d = 1'b1;
                end
            end
            S_WDRAIN: begin
                if (!first_q && weight_drain_done) begin
                    state_d = S_MMU;
                    first_d = 1'b1;
                    m_d     = '0;
                end
            end
            S_MMU: begin
                if (!first_q && mmu_done) begin
                    first_d = 1'b1;
                    if (k_last) begin
                        state_d = S_WB;
                    end else begin
                        state_d = adv_state;
                        m_d     = adv_m;
                        k_d     = adv_k;
                        n_d     = adv_n;
                    end
                end
            end
            S_WB: begin
                if (!first_q && wb_done) begin
                    first_d = 1'b1;
                    state_d = adv_state;
                    m_d     = adv_m;
                    k_d     = adv_k;
                    n_d     = adv_n;
                end
            end
            default: begin
                state_d = S_IDLE;
                m_d     = '0;
                k_d     = '0;
                n_d     = '0;
            end
        endcase
        if (abort && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
            first_d = 1'b0;
            m_d     = '0;
            k_d     = '0;
            n_d     = '0;
        end
    end

    // State register and tile position counters
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
            first_q <= 1'b0;
            m_q     <= '0;
            k_q     <= '0;
            n_q     <= '0;
        end else begin
            state_q <= state_d;
            first_q <= first_d;
            m_q     <= m_d;
            k_q     <= k_d;
            n_q     <= n_d;
        end
    end

    // Job configuration: dims/relu captured at start, tile counts in CHECK
    always_ff @(posedge clk) begin
        if (!reset) begin
            dim_m_q <= '0;
            dim_k_q <= '0;
            dim_n_q <= '0;
            relu_q  <= 1'b0;
            tm_q    <= '0;
            tk_q    <= '0;
            tn_q    <= '0;
        end else begin
            if ((state_q == S_IDLE) && start) begin
                dim_m_q <= dim_m;
                dim_k_q <= dim_k;
                dim_n_q <= dim_n;
                relu_q  <= relu_in;
            end
            if (state_q == S_CHECK) begin
                tm_q <= tm_sum[LOG_WH +: CNT_WIDTH];
                tk_q <= tk_sum[LOG_WH +: CNT_WIDTH];
                tn_q <= tn_sum[LOG_WH +: CNT_WIDTH];
            end
        end
    end

    // Outputs; tile data is held at zero outside the engine states
    always_comb begin
        logic                  active;
        logic [DIM_WIDTH-1:0]  row_rem, col_rem;
        logic [ADDR_WIDTH-1:0] w_idx, i_idx, o_idx;
        active  = (state_q == S_WFILL) || (state_q == S_WDRAIN) ||
                  (state_q == S_MMU)   || (state_q == S_WB);
        row_rem = dim_m_q - (DIM_WIDTH'(m_q) << LOG_WH);
        col_rem = dim_n_q - (DIM_WIDTH'(n_q) << LOG_WH);
        w_idx   = ADDR_WIDTH'(n_q) * ADDR_WIDTH'(tk_q) + ADDR_WIDTH'(k_q);
        i_idx   = ADDR_WIDTH'(m_q) * ADDR_WIDTH'(tk_q) + ADDR_WIDTH'(k_q);
        o_idx   = ADDR_WIDTH'(m_q) * ADDR_WIDTH'(tn_q) + ADDR_WIDTH'(n_q);

        weight_fill_start  = first_q && (state_q == S_WFILL);
        weight_drain_start = first_q && (state_q == S_WDRAIN);
        mmu_start          = first_q && (state_q == S_MMU);
        wb_start           = first_q && (state_q == S_WB);
        busy               = (state_q != S_IDLE);
        done               = (state_q == S_DONE) || (state_q == S_ERR);
        error              = (state_q == S_ERR);
        relu_en            = relu_q && busy;

        weight_base = '0;
        input_base  = '0;
        output_base = '0;
        submat_row  = '0;
        submat_col  = '0;
        accum_first = 1'b0;
        tile_rows   = '0;
        tile_cols   = '0;
        if (active) begin
            weight_base = w_idx << LOG_WH;
            input_base  = i_idx << LOG_WH;
            output_base = o_idx << LOG_WH;
            submat_row  = m_q;
            submat_col  = n_q;
            accum_first = (k_q == '0);
            tile_rows   = (row_rem >= DIM_WIDTH'(WIDTH_HEIGHT)) ?
                          EXT_WIDTH'(WIDTH_HEIGHT) : row_rem[EXT_WIDTH-1:0];
            tile_cols   = (col_rem >= DIM_WIDTH'(WIDTH_HEIGHT)) ?
                          EXT_WIDTH'(WIDTH_HEIGHT) : col_rem[EXT_WIDTH-1:0];
        end
    end

endmodule

// File: tb/tb_tile_sequencer.sv
// Bench for tile_sequencer: engine responders, an event monitor and a
// loop-nest reference model of the expected engine launch sequence.
module tb_tile_sequencer;

    localparam int WH = 16;
    localparam int MAXD = 128;
    localparam int DW = 8;
    localparam int TW = 3;
    localparam int AW = 10;
    localparam int EW = 5;

    logic          clk = 1'b0;
    logic          reset, start, abort, relu_in;
    logic [DW-1:0] dim_m, dim_k, dim_n;
    logic          weight_fill_done, weight_drain_done, mmu_done, wb_done;
    logic          weight_fill_start, weight_drain_start, mmu_start, wb_start;
    logic [AW-1:0] weight_base, input_base, output_base;
    logic [TW-1:0] submat_row, submat_col;
    logic          accum_first;
    logic [EW-1:0] tile_rows, tile_cols;
    logic          relu_en, busy, done, error;

    tile_sequencer dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort), .relu_in(relu_in),
        .dim_m(dim_m), .dim_k(dim_k), .dim_n(dim_n),
        .weight_fill_done(weight_fill_done), .weight_drain_done(weight_drain_done),
        .mmu_done(mmu_done), .wb_done(wb_done),
        .weight_fill_start(weight_fill_start), .weight_drain_start(weight_drain_start),
        .mmu_start(mmu_start), .wb_start(wb_start),
        .weight_base(weight_base), .input_base(input_base), .output_base(output_base),
        .submat_row(submat_row), .submat_col(submat_col), .accum_first(accum_first),
        .tile_rows(tile_rows), .tile_cols(tile_cols), .relu_en(relu_en),
        .busy(busy), .done(done), .error(error)
    );

    initial forever #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // one engine launch as seen by the engine (kind 0 fill,1 drain,2 mmu,3 wb)
    typedef struct packed {
        logic [1:0]    kind;
        logic [AW-1:0] wbase, ibase, obase;
        logic [TW-1:0] srow, scol;
        logic          accf;
        logic [EW-1:0] trows, tcols;
        logic          relu;
    } ev_t;

    typedef struct {
        int m, k, n;
        bit relu;
        int dly;
        bit spur;
        bit err;
        int nf, nmm, nwb;
    } vec_t;

    int  tests = 0, fails = 0;
    ev_t exp_q[$];
    int  resp_delay = 3;
    bit  spur_same = 0, spur_mmu = 0;
    int  clr_tok = 0;

    // owned by the responder process
    ev_t evq[$];
    ev_t snap[4];
    int  cnt[4];
    int  done_cnt, done_cyc, first_fill_cyc, last_wbdone_cyc, unstable, stray_err, clr_seen;
    bit  err_seen;

    function automatic ev_t make_ev(int e);
        ev_t v = '0;
        v.kind = 2'(e);
        case (e)
            0, 1: v.wbase = weight_base;
            2: begin
                v.ibase = input_base; v.srow = submat_row; v.scol = submat_col;
                v.accf = accum_first;
            end
            default: begin
                v.obase = output_base; v.srow = submat_row; v.scol = submat_col;
                v.trows = tile_rows; v.tcols = tile_cols; v.relu = relu_en;
            end
        endcase
        return v;
    endfunction

    function automatic logic [63:0] outs();
        return 64'({weight_fill_start, weight_drain_start, mmu_start, wb_start,
                    weight_base, input_base, output_base, submat_row, submat_col,
                    accum_first, tile_rows, tile_cols, relu_en, busy, done, error});
    endfunction

    function automatic int cnt_kind(int kd);
        int c = 0;
        foreach (evq[i]) if (int'(evq[i].kind) == kd) c++;
        return c;
    endfunction

    // Engine responders and launch monitor, all on the falling edge
    initial begin : responder
        logic [3:0] st, dn;
        ev_t cur;
        weight_fill_done = 0; weight_drain_done = 0; mmu_done = 0; wb_done = 0;
        clr_seen = 0; done_cnt = 0; done_cyc = -1; first_fill_cyc = -1;
        last_wbdone_cyc = -1; unstable = 0; stray_err = 0; err_seen = 0;
        for (int e = 0; e < 4; e++) begin cnt[e] = 0; snap[e] = '0; end
        forever begin
            @(negedge clk);
            if (clr_seen != clr_tok) begin
                clr_seen = clr_tok; evq.delete(); done_cnt = 0; done_cyc = -1;
                first_fill_cyc = -1; last_wbdone_cyc = -1; unstable = 0;
                stray_err = 0; err_seen = 0;
            end
            st = {wb_start, mmu_start, weight_drain_start, weight_fill_start};
            dn = '0;
            for (int e = 0; e < 4; e++) begin
                cur = make_ev(e);
                if (cnt[e] > 0) begin
                    if (busy && cur != snap[e]) unstable++;
                    cnt[e]--;
                    if (cnt[e] == 0) begin
                        dn[e] = 1'b1;
                        if (e == 3) last_wbdone_cyc = cyc;
                    end
                end
                if (st[e]) begin
                    evq.push_back(cur);
                    snap[e] = cur;
                    cnt[e] = resp_delay;
                    if (spur_same) dn[e] = 1'b1;
                    if (e == 0 && first_fill_cyc < 0) first_fill_cyc = cyc;
                end
            end
            if (spur_mmu) dn[2] = 1'b1;
            if (done) begin done_cnt++; done_cyc = cyc; err_seen = error; end
            else if (error) stray_err++;
            {wb_done, mmu_done, weight_drain_done, weight_fill_done} = dn;
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    // Expected launches straight from the loop nest: n outer, k middle, m inner
    task automatic build_model(input int dm, dk, dn, input bit r, output bit err);
        int tm, tk, tn;
        ev_t e;
        exp_q.delete();
        err = (dm == 0 || dk == 0 || dn == 0 || dm > MAXD || dk > MAXD || dn > MAXD);
        if (err) return;
        tm = (dm + WH - 1) / WH; tk = (dk + WH - 1) / WH; tn = (dn + WH - 1) / WH;
        for (int n = 0; n < tn; n++)
            for (int k = 0; k < tk; k++) begin
                e = '0; e.kind = 2'd0; e.wbase = AW'((n * tk + k) * WH);
                exp_q.push_back(e);
                e.kind = 2'd1;
                exp_q.push_back(e);
                for (int m = 0; m < tm; m++) begin
                    e = '0; e.kind = 2'd2; e.ibase = AW'((m * tk + k) * WH);
                    e.srow = TW'(m); e.scol = TW'(n); e.accf = (k == 0);
                    exp_q.push_back(e);
                    if (k == tk - 1) begin
                        e = '0; e.kind = 2'd3; e.obase = AW'((m * tn + n) * WH);
                        e.srow = TW'(m); e.scol = TW'(n); e.relu = r;
                        e.trows = EW'((dm - m * WH) < WH ? (dm - m * WH) : WH);
                        e.tcols = EW'((dn - n * WH) < WH ? (dn - n * WH) : WH);
                        exp_q.push_back(e);
                    end
                end
            end
    endtask

    task automatic run_job(input int m, k, n, input bit r, input int dly, input bit spur,
                           input bit disturb, output int nf, output int nmm,
                           output int nwb, output bit err_out);
        bit exp_err;
        int t0, lim;
        build_model(m, k, n, r, exp_err);
        resp_delay = dly; spur_same = spur; clr_tok++;
        tick(); tick();
        dim_m = DW'(m); dim_k = DW'(k); dim_n = DW'(n); relu_in = r; start = 1; t0 = cyc;
        tick();
        start = 0;
        if (disturb) begin
            for (int i = 0; i < 200 && first_fill_cyc < 0; i++) tick();
            tick(); start = 1; spur_mmu = 1;
            tick(); start = 0; spur_mmu = 0;
        end
        for (int i = 0; i < 20000 && done_cnt == 0; i++) tick();
        check("job_done_seen", 64'(done_cnt > 0), 1);
        repeat (3) tick();
        check("done_single_pulse", 64'(done_cnt), 1);
        check("busy_after_done", 64'(busy), 0);
        check("error_flag", 64'(err_seen), 64'(exp_err));
        check("stray_error", 64'(stray_err), 0);
        check("base_stability", 64'(unstable), 0);
        check("launch_count", 64'(evq.size()), 64'(exp_q.size()));
        lim = evq.size() < exp_q.size() ? evq.size() : exp_q.size();
        for (int i = 0; i < lim; i++) check($sformatf("launch%0d", i), 64'(evq[i]), 64'(exp_q[i]));
        if (exp_err) check("err_latency", 64'(done_cyc - t0), 2);
        else begin
            check("fill_latency", 64'(first_fill_cyc - t0), 2);
            check("done_latency", 64'(done_cyc - last_wbdone_cyc), 1);
        end
        nf = cnt_kind(0); nmm = cnt_kind(2); nwb = cnt_kind(3); err_out = err_seen;
    endtask

    initial begin
        vec_t tbl[8];
        int   nf, nmm, nwb, n0, j, rm, rk, rn;
        bit   e;
        int   exp_ib[4] = '{0, 32, 16, 48};
        int   exp_af[4] = '{1, 1, 0, 0};
        int   exp_ob[6] = '{0, 48, 16, 64, 32, 80};
        int   exp_tr[6] = '{16, 1, 16, 1, 16, 1};
        int   exp_tc[6] = '{16, 16, 16, 16, 8, 8};

        reset = 0; start = 0; abort = 0; relu_in = 0; dim_m = 0; dim_k = 0; dim_n = 0;
        repeat (3) tick();
        check("reset_outputs", outs(), 0);
        reset = 1;
        tick();

        //         m    k    n   relu dly spur err nf  nmm nwb
        tbl[0] = '{16,  16,  16,  0,  3,  0,   0,  1,  1,  1};
        tbl[1] = '{32,  32,  16,  1,  3,  0,   0,  2,  4,  2};
        tbl[2] = '{17,  8,   40,  0,  2,  1,   0,  3,  6,  6};
        tbl[3] = '{16,  0,   16,  0,  3,  0,   1,  0,  0,  0};
        tbl[4] = '{16,  16,  129, 0,  3,  0,   1,  0,  0,  0};
        tbl[5] = '{128, 16,  16,  0,  1,  0,   0,  1,  8,  8};
        tbl[6] = '{1,   1,   1,   1,  1,  1,   0,  1,  1,  1};
        tbl[7] = '{40,  128, 24,  1,  2,  0,   0,  16, 48, 6};
        for (int i = 0; i < 8; i++) begin
            run_job(tbl[i].m, tbl[i].k, tbl[i].n, tbl[i].relu, tbl[i].dly, tbl[i].spur, 0,
                    nf, nmm, nwb, e);
            check($sformatf("tbl%0d_err", i), 64'(e), 64'(tbl[i].err));
            check($sformatf("tbl%0d_fills", i), 64'(nf), 64'(tbl[i].nf));
            check($sformatf("tbl%0d_mmus", i), 64'(nmm), 64'(tbl[i].nmm));
            check($sformatf("tbl%0d_wbs", i), 64'(nwb), 64'(tbl[i].nwb));
        end

        // 32x32x16: input bases and accumulate mode in launch order
        run_job(32, 32, 16, 0, 3, 0, 0, nf, nmm, nwb, e);
        j = 0;
        foreach (evq[i]) if (evq[i].kind == 2'd2 && j < 4) begin
            check($sformatf("m32_ibase%0d", j), 64'(evq[i].ibase), 64'(exp_ib[j]));
            check($sformatf("m32_accf%0d", j), 64'(evq[i].accf), 64'(exp_af[j]));
            j++;
        end

        // 17x8x40: writeback bases and partial extents
        run_job(17, 8, 40, 0, 3, 0, 0, nf, nmm, nwb, e);
        j = 0;
        foreach (evq[i]) if (evq[i].kind == 2'd3 && j < 6) begin
            check($sformatf("m17_obase%0d", j), 64'(evq[i].obase), 64'(exp_ob[j]));
            check($sformatf("m17_rows%0d", j), 64'(evq[i].trows), 64'(exp_tr[j]));
            check($sformatf("m17_cols%0d", j), 64'(evq[i].tcols), 64'(exp_tc[j]));
            j++;
        end

        // start while busy plus a spurious mmu_done during WFILL
        run_job(32, 32, 16, 1, 4, 0, 1, nf, nmm, nwb, e);

        // abort during the MMU of the second tile
        resp_delay = 3; spur_same = 0; clr_tok++;
        tick(); tick();
        dim_m = 32; dim_k = 16; dim_n = 16; start = 1;
        tick();
        start = 0;
        for (int i = 0; i < 500 && cnt_kind(2) < 2; i++) tick();
        check("abort_reached_mmu2", 64'(cnt_kind(2)), 2);
        abort = 1;
        tick();
        abort = 0;
        check("abort_busy", 64'(busy), 0);
        check("abort_outputs", outs(), 0);
        n0 = evq.size();
        repeat (8) tick();
        check("abort_no_launch", 64'(evq.size()), 64'(n0));
        check("abort_no_done", 64'(done_cnt), 0);
        run_job(16, 16, 16, 0, 3, 0, 0, nf, nmm, nwb, e);

        // reset low mid-WFILL after a busy start and a spurious done
        resp_delay = 6; clr_tok++;
        tick(); tick();
        dim_m = 32; dim_k = 32; dim_n = 16; start = 1;
        tick();
        start = 0;
        for (int i = 0; i < 50 && first_fill_cyc < 0; i++) tick();
        check("rst_reached_wfill", 64'(first_fill_cyc >= 0), 1);
        tick(); start = 1; spur_mmu = 1;
        tick(); start = 0; spur_mmu = 0; reset = 0;
        tick(); reset = 1;
        check("rst_busy", 64'(busy), 0);
        check("rst_outputs", outs(), 0);
        n0 = evq.size();
        repeat (10) tick();
        check("rst_no_launch", 64'(evq.size()), 64'(n0));
        check("rst_no_done", 64'(done_cnt), 0);

        // randomized jobs against the reference model
        for (int i = 0; i < 20; i++) begin
            rm = $urandom_range(1, 64); rk = $urandom_range(1, 64); rn = $urandom_range(1, 64);
            if ($urandom_range(0, 4) == 0) rk = $urandom_range(65, 128);
            if ($urandom_range(0, 9) == 0) rm = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(129, 255);
            run_job(rm, rk, rn, 1'($urandom_range(0, 1)), $urandom_range(1, 4),
                    1'($urandom_range(0, 1)), 0, nf, nmm, nwb, e);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
